// File: rtl/capture_trigger_ctrl.sv
// Logic-analyzer capture sequencer: pre-trigger fill, armed wait and
// post-trigger count over a circular sample RAM of arbitrary depth.
module capture_trigger_ctrl #(
   parameter int ENTRIES = 384,
   parameter int ADDR_W  = 9,
   parameter int NCH     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              clr_done,
   input  logic [ADDR_W-1:0] trig_pos,
   input  logic              sample_tick,
   input  logic [NCH-1:0]    ch_trig,
   output logic              armed,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic              triggered,
   output logic              capture_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_ARM  = 3'd2;
   localparam logic [2:0] S_POST = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int CW = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] post_n;
   logic [CW-1:0]     pre_n;
   logic [CW-1:0]     pre_cnt;
   logic [CW-1:0]     post_cnt;
   logic [CW-1:0]     pre_inc;
   logic [CW-1:0]     post_inc;
   logic [ADDR_W-1:0] waddr_nxt;
   logic [ADDR_W-1:0] post_clamp;
   logic              capturing;
   logic              trig;

   assign capturing = (state == S_PRE) | (state == S_ARM) |
                      (state == S_POST);
   assign we           = sample_tick & capturing;
   assign armed        = (state == S_ARM) | (state == S_POST);
   assign capture_done = (state == S_DONE);
   assign trig         = &ch_trig;

   // Depth need not be a power of two, so wrap explicitly.
   assign waddr_nxt  = (waddr == LAST) ? '0 : waddr + ADDR_W'(1);
   assign pre_inc    = pre_cnt + CW'(1);
   assign post_inc   = post_cnt + CW'(1);
   assign post_clamp = (trig_pos > LAST) ? LAST : trig_pos;
   assign pre_n      = CW'(ENTRIES) - CW'(post_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         waddr     <= '0;
         post_n    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         triggered <= 1'b0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  waddr     <= '0;
                  pre_cnt   <= '0;
                  post_cnt  <= '0;
                  triggered <= 1'b0;
                  post_n    <= post_clamp;
                  state     <= S_PRE;
               end
            end
            S_PRE: begin
               if (we) begin
                  waddr   <= waddr_nxt;
                  pre_cnt <= pre_inc;
                  if (pre_inc == pre_n) state <= S_ARM;
               end
            end
            S_ARM: begin
               // A write in the trigger cycle still belongs to pre-trigger.
               if (we) waddr <= waddr_nxt;
               if (trig) begin
                  triggered <= 1'b1;
                  state     <= (post_n == '0) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (we) begin
                  waddr    <= waddr_nxt;
                  post_cnt <= post_inc;
                  if (post_inc == CW'(post_n)) state <= S_DONE;
               end
            end
            S_DONE: begin
               if (clr_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
